// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and result bus between the vALU control/mux and seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN to honour signed_op (two's-complement divide plus MIN/-1 overflow flag).
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_dvd, r_dsr, r_quot, r_remo;
    logic             r_dz;
    logic             w_accept, w_dz, w_ovf, w_special, w_sgn_a, w_sgn_b;
    logic             w_busy, w_done;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_shift, w_trial;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic r_qneg, r_rneg, r_ovf;

    assign w_sgn_a = bus.signed_op & bus.dividend[WIDTH-1];
    assign w_sgn_b = bus.signed_op & bus.divisor[WIDTH-1];
    assign w_ovf   = bus.signed_op && (bus.dividend == MIN) && (&bus.divisor);
`else
    assign w_sgn_a = 1'b0;
    assign w_sgn_b = 1'b0;
    assign w_ovf   = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && bus.start;
    assign w_dz      = (bus.divisor == '0);
    assign w_special = w_dz | w_ovf;
    assign w_mag_a   = w_sgn_a ? -bus.dividend : bus.dividend;
    assign w_mag_b   = w_sgn_b ? -bus.divisor  : bus.divisor;
    // Partial remainder < divisor, so the W+1-bit trial never loses the borrow.
    assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dsr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Special cases pass through FIX so their latency is a fixed two cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = w_special ? S_FIX : S_ITER;
            S_ITER:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_ITER, S_FIX: w_busy = 1'b1;
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dz   <= 1'b0;
`ifdef DIV_SIGNED_EN
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= CW'(WIDTH-1);
            r_dz  <= w_dz;
            r_dsr <= w_mag_b;
`ifdef DIV_SIGNED_EN
            r_ovf  <= w_ovf;
            r_qneg <= w_special ? 1'b0 : (w_sgn_a ^ w_sgn_b);
            r_rneg <= w_special ? 1'b0 : w_sgn_a;
`endif
            // Preload the FIX inputs with the fixed results of the special cases.
            if (w_dz) begin
                r_dvd <= '1;
                r_rem <= bus.dividend;
`ifdef DIV_SIGNED_EN
            end else if (w_ovf) begin
                r_dvd <= MIN;
                r_rem <= '0;
`endif
            end else begin
                r_dvd <= w_mag_a;
                r_rem <= '0;
            end
        end else if (r_state == S_ITER) begin
            r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_trial[WIDTH]};
            r_cnt <= r_cnt - 1'b1;
        end else if (r_state == S_FIX) begin
`ifdef DIV_SIGNED_EN
            r_quot <= r_qneg ? -r_dvd : r_dvd;
            r_remo <= r_rneg ? -r_rem : r_rem;
`else
            r_quot <= r_dvd;
            r_remo <= r_rem;
`endif
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remo;
    assign bus.div_by_zero = r_dz;
`ifdef DIV_SIGNED_EN
    assign bus.overflow    = r_ovf;
`else
    assign bus.overflow    = 1'b0;
`endif
endmodule
